clock_timekeeper: RTL and testbench



---
 rtl/clock_pkg.sv | 18 +
 rtl/clock_debounce.sv | 46 ++++
 rtl/clock_timekeeper.sv | 86 ++++++++
 tb/tb_clock_timekeeper.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared digit type, rollover limits, default dividers and BCD helpers
package clock_pkg;
    typedef logic [3:0] bcd_t;
    localparam int HOUR_MAX     = 23;
    localparam int MIN_MAX      = 59;
    localparam int SEC_MAX      = 59;
    localparam int TICK_DIV_DEF = 16000000;
    localparam int TEST_DIV_DEF = 16000;
    localparam int DEB_CYC_DEF  = 160000;
    // True when the two-digit BCD value equals lim.
    function automatic logic bcd_at(input bcd_t t, input bcd_t u, input int lim);
        return t == bcd_t'(lim / 10) && u == bcd_t'(lim % 10);
    endfunction
    // Two-digit BCD increment that wraps to 00 after lim.
    function automatic logic [7:0] bcd_inc(input bcd_t t, input bcd_t u, input int lim);
        return bcd_at(t, u, lim) ? 8'h00 : (u == 4'd9) ? {t + 4'd1, 4'd0} : {t, u + 4'd1};
    endfunction
endpackage

// File: rtl/clock_debounce.sv
// clock_debounce: 2-flop synchronizer, stable-count debouncer and press pulse for one switch
// Ports: mclk/rst_n (sync, active-low); raw_n raw active-low switch;
//        lvl debounced level (1 = released); press one-cycle pulse on a debounced 1->0 edge.
module clock_debounce
    import clock_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic raw_n,
    output logic lvl,
    output logic press
);
    localparam int CW = $clog2(DEB_CYC + 1);
    logic s1_q, s1_d, s2_q, s2_d, deb_q, deb_d, lvl_q, lvl_d, press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        s1_d    = raw_n;
        s2_d    = s1_q;
        cnt_d   = (s2_q == deb_q || cnt_q == CW'(DEB_CYC - 1)) ? '0 : cnt_q + CW'(1);
        deb_d   = (s2_q != deb_q && cnt_q == CW'(DEB_CYC - 1)) ? s2_q : deb_q;
        lvl_d   = deb_q;
        press_d = lvl_q & ~deb_q;
    end
    // Synchronizer flops reset to the released level so reset release causes no spurious mismatch.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            cnt_q   <= '0;
            deb_q   <= 1'b1;
            lvl_q   <= 1'b1;
            press_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
        end
    end
    assign lvl   = lvl_q;
    assign press = press_q;
endmodule

// File: rtl/clock_timekeeper.sv
// clock_timekeeper: switch conditioning, one-second prescaler and BCD hh:mm:ss counter chain
// Ports: mclk/rst_n (sync, active-low); ts_n, hs_n, ms_n, test_n raw active-low switches;
//        hour/min/sec tens+units BCD digits; sec_tick one-cycle update pulse; set_mode debounced time-set.
module clock_timekeeper
    import clock_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int TEST_DIV = TEST_DIV_DEF,
    parameter int DEB_CYC  = DEB_CYC_DEF
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       ts_n,
    input  logic       hs_n,
    input  logic       ms_n,
    input  logic       test_n,
    output logic [3:0] hour_t,
    output logic [3:0] hour_u,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       sec_tick,
    output logic       set_mode
);
    localparam int MAX_DIV = TICK_DIV > TEST_DIV ? TICK_DIV : TEST_DIV;
    localparam int PW      = $clog2(MAX_DIV + 1);
    logic ts_lvl, ts_press, hs_press, ms_press, test_lvl;
    logic unused_hs_lvl, unused_ms_lvl, unused_test_press;
    logic [PW-1:0] limit, pre_q, pre_d;
    logic hold, sec_carry, min_step, hour_step;
    logic set_mode_q, set_mode_d, sec_tick_q, sec_tick_d;
    bcd_t hour_t_q, hour_t_d, hour_u_q, hour_u_d, min_t_q, min_t_d, min_u_q, min_u_d;
    bcd_t sec_t_q, sec_t_d, sec_u_q, sec_u_d;
    clock_debounce #(.DEB_CYC(DEB_CYC)) u_ts   (.mclk(mclk), .rst_n(rst_n), .raw_n(ts_n),   .lvl(ts_lvl),        .press(ts_press));
    clock_debounce #(.DEB_CYC(DEB_CYC)) u_hs   (.mclk(mclk), .rst_n(rst_n), .raw_n(hs_n),   .lvl(unused_hs_lvl), .press(hs_press));
    clock_debounce #(.DEB_CYC(DEB_CYC)) u_ms   (.mclk(mclk), .rst_n(rst_n), .raw_n(ms_n),   .lvl(unused_ms_lvl), .press(ms_press));
    clock_debounce #(.DEB_CYC(DEB_CYC)) u_test (.mclk(mclk), .rst_n(rst_n), .raw_n(test_n), .lvl(test_lvl),      .press(unused_test_press));
    always_comb begin
        limit      = test_lvl ? PW'(TICK_DIV) : PW'(TEST_DIV);
        // ts_press marks the cycle set mode is being entered, so it beats a coinciding tick;
        // set_mode_q still high on the leaving edge keeps the prescaler at 0 for a full period.
        hold       = set_mode_q | ts_press;
        set_mode_d = ~ts_lvl;
        sec_tick_d = ~hold & (pre_q == limit - PW'(1));
        // >= also catches a count stranded above a freshly shortened limit: clear without a tick.
        pre_d      = (hold || pre_q >= limit - PW'(1)) ? '0 : pre_q + PW'(1);
        sec_carry  = sec_tick_d & bcd_at(sec_t_q, sec_u_q, SEC_MAX);
        min_step   = hold ? ms_press : sec_carry;
        hour_step  = hold ? hs_press : sec_carry & bcd_at(min_t_q, min_u_q, MIN_MAX);
        {sec_t_d, sec_u_d}   = hold ? 8'h00 : sec_tick_d ? bcd_inc(sec_t_q, sec_u_q, SEC_MAX) : {sec_t_q, sec_u_q};
        {min_t_d, min_u_d}   = min_step ? bcd_inc(min_t_q, min_u_q, MIN_MAX) : {min_t_q, min_u_q};
        {hour_t_d, hour_u_d} = hour_step ? bcd_inc(hour_t_q, hour_u_q, HOUR_MAX) : {hour_t_q, hour_u_q};
    end
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            pre_q      <= '0;
            set_mode_q <= 1'b0;
            sec_tick_q <= 1'b0;
            hour_t_q   <= '0;
            hour_u_q   <= '0;
            min_t_q    <= '0;
            min_u_q    <= '0;
            sec_t_q    <= '0;
            sec_u_q    <= '0;
        end else begin
            pre_q      <= pre_d;
            set_mode_q <= set_mode_d;
            sec_tick_q <= sec_tick_d;
            hour_t_q   <= hour_t_d;
            hour_u_q   <= hour_u_d;
            min_t_q    <= min_t_d;
            min_u_q    <= min_u_d;
            sec_t_q    <= sec_t_d;
            sec_u_q    <= sec_u_d;
        end
    end
    assign hour_t   = hour_t_q;
    assign hour_u   = hour_u_q;
    assign min_t    = min_t_q;
    assign min_u    = min_u_q;
    assign sec_t    = sec_t_q;
    assign sec_u    = sec_u_q;
    assign sec_tick = sec_tick_q;
    assign set_mode = set_mode_q;
endmodule

// File: tb/tb_clock_timekeeper.sv
// tb_clock_timekeeper: directed scenarios plus random switch activity against a seconds-of-day model
module tb_clock_timekeeper;
    localparam int TICK = 10;
    localparam int TEST = 2;
    localparam int DEB  = 4;
    logic mclk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] sw = 4'hF;
    logic [3:0] hour_t, hour_u, min_t, min_u, sec_t, sec_u;
    logic sec_tick, set_mode;
    logic [23:0] dt;
    int tests = 0, fails = 0;
    int tick_cnt, gmin, gmax, last_tick, ncyc = 0;
    bit rh [4][8];
    bit deb [4], lvl [4], prs [4];
    bit m_set, m_tick, m_valid = 0;
    int m_pre, m_h, m_m, m_s;

    always #5 mclk = ~mclk;

    clock_timekeeper #(.TICK_DIV(TICK), .TEST_DIV(TEST), .DEB_CYC(DEB)) dut (
        .mclk(mclk), .rst_n(rst_n), .ts_n(sw[0]), .hs_n(sw[1]), .ms_n(sw[2]), .test_n(sw[3]),
        .hour_t(hour_t), .hour_u(hour_u), .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
        .sec_tick(sec_tick), .set_mode(set_mode)
    );
    assign dt = {hour_t, hour_u, min_t, min_u, sec_t, sec_u};

    function automatic logic [23:0] bcd6(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a switch's debounced level flips once the synced samples (raw delayed two edges)
    // have disagreed with it DEB times in a row; time is kept as seconds of the day.
    always @(posedge mclk) begin
        bit hold, all;
        int lim, t;
        if (!rst_n) begin
            foreach (rh[i, k]) rh[i][k] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                deb[i] = 1'b1;
                lvl[i] = 1'b1;
                prs[i] = 1'b0;
            end
            m_set = 0; m_tick = 0; m_pre = 0; m_h = 0; m_m = 0; m_s = 0;
            m_valid = 1;
        end else begin
            hold = m_set || !lvl[0];
            lim = lvl[3] ? TICK : TEST;
            m_set = !lvl[0];
            m_tick = 0;
            if (hold) begin
                m_pre = 0;
                m_s = 0;
                if (prs[1]) m_h = (m_h + 1) % 24;
                if (prs[2]) m_m = (m_m + 1) % 60;
            end else if (m_pre >= lim - 1) begin
                if (m_pre == lim - 1) begin
                    m_tick = 1;
                    t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                    m_h = t / 3600;
                    m_m = (t / 60) % 60;
                    m_s = t % 60;
                end
                m_pre = 0;
            end else begin
                m_pre++;
            end
            for (int i = 0; i < 4; i++) begin
                prs[i] = lvl[i] && !deb[i];
                lvl[i] = deb[i];
                for (int k = 7; k > 0; k--) rh[i][k] = rh[i][k - 1];
                rh[i][0] = sw[i];
                all = 1;
                for (int k = 2; k < DEB + 2; k++) if (rh[i][k] == deb[i]) all = 0;
                if (all) deb[i] = !deb[i];
            end
        end
    end

    always @(negedge mclk) begin
        if (m_valid) begin
            chk("time", {8'h0, dt}, {8'h0, bcd6(m_h, m_m, m_s)});
            chk("sec_tick", {31'h0, sec_tick}, {31'h0, m_tick});
            chk("set_mode", {31'h0, set_mode}, {31'h0, m_set});
        end
    end

    always @(posedge mclk) begin
        #2;
        ncyc++;
        if (sec_tick === 1'b1) begin
            tick_cnt++;
            if (last_tick >= 0) begin
                if (ncyc - last_tick < gmin) gmin = ncyc - last_tick;
                if (ncyc - last_tick > gmax) gmax = ncyc - last_tick;
            end
            last_tick = ncyc;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic press(input int i);
        sw[i] = 1'b0;
        cyc(7);
        sw[i] = 1'b1;
        cyc(7);
    endtask

    task automatic mon_clear();
        tick_cnt = 0;
        gmin = 1000000;
        gmax = 0;
        last_tick = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        mon_clear();
        cyc(3);
        chk("reset_time", {8'h0, dt}, 32'h000000);
        chk("reset_tick", {31'h0, sec_tick}, 0);
        rst_n = 1'b1;
        mon_clear();
        // 1: 600 cycles of normal run
        cyc(600);
        chk("s1_time", {8'h0, dt}, 32'h000100);
        chk("s1_ticks", tick_cnt, 60);
        chk("s1_gap_min", gmin, 10);
        chk("s1_gap_max", gmax, 10);
        // 2: preload 23:59 in set mode, run through midnight
        sw[0] = 1'b0;
        cyc(8);
        for (int g = 0; g < 40 && m_h != 23; g++) press(1);
        for (int g = 0; g < 80 && m_m != 59; g++) press(2);
        chk("s2_preload", {8'h0, dt}, 32'h235900);
        sw[0] = 1'b1;
        for (int g = 0; g < 1000 && m_s != 58; g++) cyc(1);
        chk("s2_at58", {8'h0, dt}, 32'h235958);
        cyc(20);
        chk("s2_wrap", {8'h0, dt}, 32'h000000);
        // 3: 61 minute presses, then 24 hour presses
        sw[0] = 1'b0;
        cyc(8);
        chk("s3_set_mode", {31'h0, set_mode}, 1);
        for (int k = 0; k < 61; k++) press(2);
        chk("s3_min", {8'h0, dt}, 32'h000100);
        for (int k = 0; k < 24; k++) press(1);
        chk("s3_hour", {8'h0, dt}, 32'h000100);
        // 4: short glitches ignored, clean press counted once after 7 cycles
        for (int k = 0; k < 4; k++) begin
            sw[1] = 1'b0;
            cyc(3);
            sw[1] = 1'b1;
            cyc(3);
        end
        cyc(8);
        chk("s4_glitch", {8'h0, dt}, 32'h000100);
        sw[1] = 1'b0;
        cyc(7);
        chk("s4_before", {8'h0, dt}, 32'h000100);
        cyc(1);
        chk("s4_after", {8'h0, dt}, 32'h010100);
        cyc(2);
        sw[1] = 1'b1;
        cyc(8);
        chk("s4_once", {8'h0, dt}, 32'h010100);
        // 5: test mode ticks every 2, then switch while prescaler is at 7
        sw[0] = 1'b1;
        cyc(8);
        sw[3] = 1'b0;
        cyc(10);
        mon_clear();
        cyc(40);
        chk("s5_ticks", tick_cnt, 20);
        chk("s5_gap_min", gmin, 2);
        chk("s5_gap_max", gmax, 2);
        sw[3] = 1'b1;
        cyc(12);
        for (int g = 0; g < 20 && m_pre != 0; g++) cyc(1);
        sw[3] = 1'b0;
        for (int k = 0; k < 9; k++) begin
            cyc(1);
            chk("s5_notick", {31'h0, sec_tick}, 0);
        end
        cyc(1);
        chk("s5_tick", {31'h0, sec_tick}, 1);
        sw[3] = 1'b1;
        cyc(10);
        // 6: reset mid-prescale at 12:34:56
        sw[0] = 1'b0;
        cyc(8);
        for (int g = 0; g < 40 && m_h != 12; g++) press(1);
        for (int g = 0; g < 80 && m_m != 34; g++) press(2);
        sw[0] = 1'b1;
        for (int g = 0; g < 1000 && m_s != 56; g++) cyc(1);
        cyc(3);
        chk("s6_before", {8'h0, dt}, 32'h123456);
        rst_n = 1'b0;
        cyc(1);
        chk("s6_reset", {8'h0, dt}, 32'h000000);
        rst_n = 1'b1;
        cyc(9);
        chk("s6_notick", {31'h0, sec_tick}, 0);
        cyc(1);
        chk("s6_tick", {31'h0, sec_tick}, 1);
        chk("s6_time", {8'h0, dt}, 32'h000001);
        // random switch activity with occasional resets, checked by the model every cycle
        for (int k = 0; k < 400; k++) begin
            int idx;
            idx = $urandom_range(0, 3);
            sw[idx] = ~sw[idx];
            if ($urandom_range(0, 60) == 0) begin
                rst_n = 1'b0;
                cyc(1);
                rst_n = 1'b1;
            end
            cyc($urandom_range(1, 12));
        end
        sw = 4'hF;
        cyc(10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
